// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory, decode handshake and redirect signals of the fetch stage
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus8;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus8, op, funct, rd,
        input  imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus8, op, funct, rd,
        output imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular prefetch FIFO of {instr, pc} entries with flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
    assign head  = mem[rd_ptr];
    assign full  = count == FULL_CNT;
    assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, single-outstanding imem requests and prefetch queue feeding decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic    clk,
    input logic    reset,
    fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);
    fetch_state_t state, state_nx;
    logic [31:0] fetch_pc, req_pc;
    logic push, pop, issue, space, full, empty;
    logic [AW:0] count;
    logic [AW+1:0] next_count;
    fetch_entry_t head;
    // issue needs room for the word it will bring back, counting this cycle's push/pop
    always_comb begin
        push       = state == WAIT && bus.imem_rvalid && !bus.redirect;
        pop        = !empty && bus.instr_ready && !bus.redirect;
        next_count = (AW+2)'(count) + (AW+2)'(push) - (AW+2)'(pop);
        space      = full ? (pop && !push) : (next_count < LIMIT);
        issue      = !reset && !bus.redirect && (state == IDLE || bus.imem_rvalid) && space;
        state_nx   = (bus.imem_rvalid || state == IDLE) ? (issue ? WAIT : IDLE)
                   : (state == WAIT && bus.redirect) ? DISCARD : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nx;
            if (bus.redirect) fetch_pc <= bus.redirect_pc & ~32'd3;
            else if (issue) fetch_pc <= fetch_pc + PC_STEP;
            if (issue) req_pc <= fetch_pc;
        end
    end
    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .din   (fetch_entry_t'{instr: bus.imem_rdata, pc: req_pc}),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = !empty;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign bus.pc_plus8    = head.pc + PC_READ_OFFSET;
    assign bus.op          = head.instr[27:26];
    assign bus.funct       = head.instr[25:20];
    assign bus.rd          = head.instr[15:12];
endmodule
